// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB requester: single-word commands to IDLE/SETUP/ACCESS transfers, one-cycle response
// Optional watchdog on stalled ACCESS phases: define APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [AWIDTH-1:0]   paddr_q, paddr_d;
  logic [DWIDTH-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [CW-1:0]       cnt_q, cnt_d;
`endif

  // Next-state and registered-output computation for the transfer sequencer
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          // Address, direction and data are latched once and held until the next accept
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          // A ready slave always wins over the watchdog in the same cycle
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
`ifdef APB_MASTER_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          cnt_d       = cnt_q + CW'(1);
        end else begin
          cnt_d       = cnt_q + CW'(1);
`endif
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any transfer in flight without a response
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Ready only while idle and out of reset
  always_comb begin
    cmd_ready = (state_q == IDLE) && !PRESET;
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master
module tb_apb_master;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          PCLK;
  logic          PRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  apb_master #(.DWIDTH(DW), .AWIDTH(AW), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic [DW-1:0] prdata;
    logic          slverr;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } sb_t;

  vec_t vecs[7];
  sb_t  sb_q[$];

  int passed = 0;
  int total  = 0;

  int            slv_waits  = 0;
  logic [DW-1:0] slv_prdata = '0;
  logic          slv_err    = 1'b0;
  logic          slv_hold   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Slave model: wait states per transfer, junk on the return lines outside ACCESS
  initial begin
    int wcnt;
    wcnt = 0;
    PREADY = 1'b1; PRDATA = 32'hBAD0BAD0; PSLVERR = 1'b1;
    forever begin
      @(posedge PCLK); #1;
      if (PSEL && PENABLE) begin
        PREADY  = !slv_hold && (wcnt == slv_waits);
        PRDATA  = PREADY ? slv_prdata : 32'hBAD0BAD0;
        PSLVERR = PREADY ? slv_err : 1'b1;
        wcnt++;
      end else begin
        PREADY  = 1'b1;
        PRDATA  = 32'hBAD0BAD0;
        PSLVERR = 1'b1;
        wcnt    = 0;
      end
    end
  end

  // Scoreboard: every response pops one expected entry
  initial begin
    sb_t e;
    forever begin
      @(negedge PCLK);
      if (!PRESET && rsp_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", rsp_err, e.err);
        end
      end
    end
  end

  // Drive one command from the rsp/idle cycle and follow it until its response
  task automatic run_xfer(input vec_t v);
    int cycles, psel_n, pen_n;
    logic stable_ok;
    slv_waits = v.waits; slv_prdata = v.prdata; slv_err = v.slverr;
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
    check("cmd_ready_before_accept", cmd_ready, 1);
    sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    cycles = 1; psel_n = 0; pen_n = 0; stable_ok = 1'b1;
    while (!rsp_valid && cycles < 50) begin
      if (PSEL) psel_n++;
      if (PENABLE) pen_n++;
      if (PSEL && (PADDR !== v.addr || PWRITE !== v.write || PWDATA !== v.wdata)) stable_ok = 1'b0;
      if (PSEL && cmd_ready) stable_ok = 1'b0;
      @(posedge PCLK); #1;
      cycles++;
    end
    check("rsp_latency", cycles, 3 + v.waits);
    check("psel_cycles", psel_n, 2 + v.waits);
    check("penable_cycles", pen_n, 1 + v.waits);
    check("bus_stable", stable_ok, 1);
    check("psel_low_in_rsp", {PSEL, PENABLE}, 0);
    check("cmd_ready_in_rsp", cmd_ready, 1);
  endtask

  initial begin
    vec_t v;
    int cyc, rsp_seen, r1, s2, low_run, max_low;
    logic started;

    vecs[0] = '{1'b1, 8'h04, 32'hA5A5_0001, 0, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 8'h08, 32'h0000_0000, 2, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 8'h10, 32'h1111_2222, 0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1};
    vecs[3] = '{1'b1, 8'h20, 32'h0BAD_CAFE, 1, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0};
    vecs[4] = '{1'b0, 8'hFF, 32'h5555_AAAA, 3, 32'h0000_0000, 1'b0, 32'h0,         1'b0};
    vecs[5] = '{1'b1, 8'h00, 32'hFFFF_FFFF, 0, 32'h7777_7777, 1'b1, 32'h0,         1'b1};
    vecs[6] = '{1'b0, 8'h80, 32'h0,         0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0};

    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    check("reset_outputs", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err}, 0);
    check("reset_paddr_pwdata", {PADDR, PWDATA}, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_cmd_ready", cmd_ready, 0);
    PRESET = 1'b0;
    #1;
    check("cmd_ready_after_reset", cmd_ready, 1);
    @(posedge PCLK); #1;

    // Table-driven transfers, each issued in the previous response cycle
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      run_xfer(v);
    end
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    check("rsp_single_pulse", rsp_valid, 0);
    check("rsp_rdata_hold", rsp_rdata, 32'hCAFE_F00D);
    check("rsp_err_hold", rsp_err, 0);

    // Back-to-back write then read with cmd_valid held high
    slv_waits = 0; slv_prdata = 32'h55AA_55AA; slv_err = 1'b0;
    sb_q.push_back('{rdata: 32'h0, err: 1'b0});
    sb_q.push_back('{rdata: 32'h55AA_55AA, err: 1'b0});
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h30; cmd_wdata = 32'h0102_0304;
    cyc = 0; rsp_seen = 0; r1 = -10; s2 = -1; low_run = 0; max_low = 0; started = 1'b0;
    while (rsp_seen < 2 && cyc < 30) begin
      @(posedge PCLK); #1;
      cyc++;
      if (cyc == 1) begin
        cmd_write = 1'b0; cmd_addr = 8'h34; cmd_wdata = 32'h0;
      end
      if (cyc == r1 + 1) cmd_valid = 1'b0;
      if (PSEL) begin
        started = 1'b1;
        low_run = 0;
      end else if (started && rsp_seen < 1) begin
        low_run++;
      end else if (started && cyc <= r1 + 1) begin
        low_run++;
      end
      if (low_run > max_low) max_low = low_run;
      if (PSEL && !PENABLE && cyc > 1 && s2 < 0) s2 = cyc;
      if (rsp_valid) begin
        rsp_seen++;
        if (rsp_seen == 1) r1 = cyc;
      end
    end
    cmd_valid = 1'b0;
    check("b2b_two_rsps", rsp_seen, 2);
    check("b2b_second_setup", s2, r1 + 1);
    check("b2b_psel_gap", max_low, 1);

    // Reset in the second ACCESS cycle aborts the transfer silently
    @(posedge PCLK); #1;
    slv_waits = 5; slv_prdata = 32'h9999_9999;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h44; cmd_wdata = 32'h0;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    check("access2_reached", {PSEL, PENABLE}, 2'b11);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    check("midreset_bus", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err}, 0);
    check("midreset_paddr_pwdata_rdata", {PADDR, PWDATA, rsp_rdata}, 0);
    check("midreset_cmd_ready", cmd_ready, 0);
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    check("postreset_no_rsp", rsp_valid, 0);
    v = '{1'b1, 8'h48, 32'hFEED_0001, 0, 32'h0, 1'b0, 32'h0, 1'b0};
    run_xfer(v);
    @(posedge PCLK); #1;

    // Stalled slave: watchdog abort, or indefinite wait without it
    slv_hold = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h50; cmd_wdata = 32'h0;
`ifdef APB_MASTER_TIMEOUT_EN
    sb_q.push_back('{rdata: 32'h0, err: 1'b1});
`endif
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    cyc = 1;
`ifdef APB_MASTER_TIMEOUT_EN
    while (!rsp_valid && cyc < 50) begin
      @(posedge PCLK); #1;
      cyc++;
    end
    check("timeout_latency", cyc, 6);
    check("timeout_psel_low", {PSEL, PENABLE}, 0);
    slv_hold = 1'b0;
    @(posedge PCLK); #1;
`else
    repeat (101) begin
      @(posedge PCLK); #1;
      cyc++;
    end
    check("stall_still_access", {PSEL, PENABLE, cmd_ready}, 3'b110);
    PRESET = 1'b1;
    slv_hold = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
`endif
    v = '{1'b0, 8'h54, 32'h0, 1, 32'h0F0F_0F0F, 1'b0, 32'h0F0F_0F0F, 1'b0};
    run_xfer(v);
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    check("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that turns single-word commands from a local control source (test sequencer, SPI bridge front end) into APB transfers toward register slaves such as the write/read configuration registers. Runs IDLE → SETUP → ACCESS per transfer, holds address, data and direction stable for the whole transfer, and waits on PREADY. Returns a one-cycle response with read data and error status. An optional watchdog aborts transfers that stall.

## Interface
- DWIDTH, 32, data width of PWDATA/PRDATA and command/response data
- AWIDTH, 8, address width of PADDR
- TIMEOUT, 16, max ACCESS cycles before abort (used only with the watchdog; must be ≥ 1)
- PCLK  input  1  single clock; all logic rising-edge
- PRESET  input  1  reset, synchronous, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  AWIDTH  target address
- cmd_wdata  input  DWIDTH  write data (ignored for reads)
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  DWIDTH  read data (0 for writes)
- rsp_err  output  1  PSLVERR sampled, or timeout
- PSEL  output  1  APB select
- PENABLE  output  1  APB enable
- PWRITE  output  1  APB direction
- PADDR  output  AWIDTH  APB address
- PWDATA  output  DWIDTH  APB write data
- PRDATA  input  DWIDTH  APB read data
- PREADY  input  1  slave ready
- PSLVERR  input  1  slave error

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1, PSEL=0, PENABLE=0. On cmd_valid, register cmd_write/addr/wdata into PWRITE/PADDR/PWDATA → SETUP.
- SETUP: PSEL=1, PENABLE=0, cmd_ready=0; unconditionally → ACCESS next cycle.
- ACCESS: PSEL=1, PENABLE=1. Stay while PREADY=0. On PREADY=1 → IDLE, capture PRDATA into rsp_rdata (reads only; 0 for writes), PSLVERR into rsp_err, and pulse rsp_valid.
- PADDR/PWRITE/PWDATA hold their values from SETUP through the last ACCESS cycle and keep them in IDLE until the next accept. No bus glitching.
- PWDATA is driven for reads with the latched cmd_wdata. Slaves must ignore it.
- One outstanding transfer. No response backpressure: the requester must take rsp_valid when it pulses.
- PREADY/PRDATA/PSLVERR are ignored outside ACCESS.
- Reset (PRESET=1 at a clock edge, any state, including mid-transfer): state=IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata and rsp_err all go to 0. cmd_ready=0 while PRESET is high. An aborted transfer produces no response.

## Timing
- Accept at edge N. SETUP is cycle N+1. The first ACCESS cycle is N+2.
- Zero-wait slave (PREADY=1 in the first ACCESS cycle): rsp_valid is high in cycle N+3, and cmd_ready is high again in N+3.
- Each PREADY=0 cycle adds 1 cycle of latency.
- Minimum 3 cycles per transfer. A new command can be accepted in the same cycle rsp_valid pulses.
- rsp_valid is high for exactly 1 cycle. rsp_rdata/rsp_err hold until the next response.

## Configuration
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT, the FSM → IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0, PSEL/PENABLE deassert.
  - PREADY=1 in the same cycle the count reaches TIMEOUT completes normally (PREADY wins).
- Undefined: no counter. ACCESS waits indefinitely for PREADY. TIMEOUT is unused.

## Test plan
- Write addr 0x04, data 0xA5A5_0001, PREADY tied 1 → PSEL 2 cycles, PENABLE 1 cycle, PWRITE=1 and PADDR=0x04 stable throughout; rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- Read addr 0x08, slave drives PRDATA=0x1234_5678 with 2 wait states → ACCESS lasts 3 cycles; rsp_rdata=0x1234_5678 at N+5.
- Back-to-back write then read, cmd_valid held high → second accept in the rsp_valid cycle; no PSEL low gap longer than 1 cycle; both responses correct.
- Read with PSLVERR=1 when PREADY=1 → rsp_err=1 for that response; next transfer rsp_err=0.
- PRESET asserted in the second ACCESS cycle → next cycle all outputs 0, no rsp_valid; after release a new write completes normally.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT=4, PREADY held 0 → rsp_valid with rsp_err=1 after 4 ACCESS cycles, PSEL=0 next. Without the macro → still in ACCESS after 100 cycles.
